// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: state encoding of the
// redirect tracker, default reset constants and the PC increment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_SEQ   = 2'd0,  // sequential fetch, no redirect outstanding
        ST_REDIR = 2'd1,  // a redirect was taken for the instruction now in D
        ST_PEND  = 2'd2   // the predicted branch has moved on to E
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] PC_STEP           = 32'd4;

    // Next sequential address; wraps naturally at 32 bits.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_unit_fd_reg.sv
// F/D pipeline register: flush inserts a bubble, stall holds, otherwise it
// captures the fetched instruction and its addresses.
module fd_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pcplus4_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pcplus4_out
);

    logic [31:0] instr_d, instr_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] pcplus4_d, pcplus4_q;

    // Next register contents: flush beats stall, stall beats load.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        if (flush) begin
            instr_d   = NOP_INSTR;
            pc_d      = 32'h0000_0000;
            pcplus4_d = PC_STEP;
        end else if (!stall) begin
            instr_d   = instr_in;
            pc_d      = pc_in;
            pcplus4_d = pcplus4_in;
        end
    end

    // Register update; reset loads the same bubble as a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= NOP_INSTR;
            pc_q      <= 32'h0000_0000;
            pcplus4_q <= PC_STEP;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
        end
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign pcplus4_out = pcplus4_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage with static predict-taken redirect from Decode and recovery on
// an Execute-stage mispredict. Holds the PC, the recovery address and the
// redirect tracking state machine; the F/D register lives in fd_reg.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         StallF,
    input  logic         StallD,
    input  logic         FlushD,
    input  logic         branch_D,
    input  logic         jump_D,
    input  logic [31:0]  target_D,
    input  logic         branch_E,
    input  logic         condition_met_E,
    input  logic [31:0]  instr_F,
    output logic [31:0]  PC_F,
    output logic [31:0]  instr_D,
    output logic [31:0]  PC_D,
    output logic [31:0]  PCPlus4_D,
    output logic         branched_flag_F,
    output logic         mispredict_F,
    output fetch_state_e dbg_state,
    output logic [31:0]  dbg_recover_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  recover_pc_q, recover_pc_d;
    logic         redir_branch_q, redir_branch_d;  // last redirect came from a branch
    logic         mispredict;
    logic         redirect;

    // A predicted-taken branch resolved not-taken in Execute.
    assign mispredict   = branch_E && !condition_met_E;
    assign mispredict_F = mispredict;

    // Redirect only once per D instruction, never while F is stalled, and
    // never from a wrong-path D instruction during a mispredict.
    assign redirect = (branch_D || jump_D) && !branched_flag_F && !StallF && !mispredict;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_SEQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: mispredict and redirect override the normal walk.
    always_comb begin
        state_d = state_q;
        if (mispredict) begin
            state_d = ST_SEQ;
        end else if (redirect) begin
            state_d = ST_REDIR;
        end else begin
            case (state_q)
                ST_REDIR: begin
                    if (!StallD) begin
                        state_d = redir_branch_q ? ST_PEND : ST_SEQ;
                    end
                end
                ST_PEND: state_d = ST_SEQ;
                default: state_d = ST_SEQ;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        branched_flag_F = (state_q == ST_REDIR);
        dbg_state       = state_q;
    end

    // PC selection and recovery-address bookkeeping.
    always_comb begin
        pc_d           = pc_q;
        recover_pc_d   = recover_pc_q;
        redir_branch_d = redir_branch_q;
        if (mispredict) begin
            pc_d = recover_pc_q;
        end else if (redirect) begin
            pc_d           = target_D;
            redir_branch_d = branch_D;
            if (branch_D) begin
                recover_pc_d = pc_plus4(PC_D);
            end
        end else if (!StallF) begin
            pc_d = pc_plus4(pc_q);
        end
    end

    // PC and recovery registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q           <= RESET_PC;
            recover_pc_q   <= 32'h0000_0000;
            redir_branch_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            recover_pc_q   <= recover_pc_d;
            redir_branch_q <= redir_branch_d;
        end
    end

    assign PC_F           = pc_q;
    assign dbg_recover_pc = recover_pc_q;

    fd_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_fd_reg (
        .clk         (clk),
        .reset       (reset),
        .stall       (StallD),
        .flush       (FlushD),
        .instr_in    (instr_F),
        .pc_in       (pc_q),
        .pcplus4_in  (pc_plus4(pc_q)),
        .instr_out   (instr_D),
        .pc_out      (PC_D),
        .pcplus4_out (PCPlus4_D)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against a behavioural model of the fetch rules.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] NOP_V   = 32'h0000_0013;
    localparam logic [31:0] RST_PC_V = 32'h0000_0000;

    logic         clk;
    logic         reset;
    logic         StallF, StallD, FlushD;
    logic         branch_D, jump_D;
    logic [31:0]  target_D;
    logic         branch_E, condition_met_E;
    logic [31:0]  instr_F;
    logic [31:0]  PC_F, instr_D, PC_D, PCPlus4_D;
    logic         branched_flag_F, mispredict_F;
    fetch_state_e dbg_state;
    logic [31:0]  dbg_recover_pc;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state.
    logic [31:0] m_pc, m_recover, m_instr_d, m_pc_d, m_pc4_d;
    bit          m_flag, m_pend, m_from_branch;

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign instr_F = mem_word(PC_F);

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .StallF          (StallF),
        .StallD          (StallD),
        .FlushD          (FlushD),
        .branch_D        (branch_D),
        .jump_D          (jump_D),
        .target_D        (target_D),
        .branch_E        (branch_E),
        .condition_met_E (condition_met_E),
        .instr_F         (instr_F),
        .PC_F            (PC_F),
        .instr_D         (instr_D),
        .PC_D            (PC_D),
        .PCPlus4_D       (PCPlus4_D),
        .branched_flag_F (branched_flag_F),
        .mispredict_F    (mispredict_F),
        .dbg_state       (dbg_state),
        .dbg_recover_pc  (dbg_recover_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock edge worth of the fetch rules, applied to the model.
    task automatic model_step();
        logic        mis, redir;
        logic [31:0] npc, nrec;
        bit          nflag, npend, nfb;
        mis   = branch_E && !condition_met_E;
        redir = (branch_D || jump_D) && !m_flag && !StallF && !mis;
        if (reset) begin
            m_pc = RST_PC_V; m_recover = 32'h0; m_flag = 0; m_pend = 0; m_from_branch = 0;
            m_instr_d = NOP_V; m_pc_d = 32'h0; m_pc4_d = 32'h4;
        end else begin
            nrec = (redir && branch_D) ? m_pc_d + 32'd4 : m_recover;
            if (mis)         npc = m_recover;
            else if (redir)  npc = target_D;
            else if (StallF) npc = m_pc;
            else             npc = m_pc + 32'd4;
            if (mis)         begin nflag = 0; npend = 0; end
            else if (redir)  begin nflag = 1; npend = 0; end
            else if (m_flag) begin nflag = StallD; npend = !StallD && m_from_branch; end
            else             begin nflag = 0; npend = 0; end
            nfb = redir ? branch_D : m_from_branch;
            if (FlushD) begin
                m_instr_d = NOP_V; m_pc_d = 32'h0; m_pc4_d = 32'h4;
            end else if (!StallD) begin
                m_instr_d = mem_word(m_pc); m_pc_d = m_pc; m_pc4_d = m_pc + 32'd4;
            end
            m_pc = npc; m_recover = nrec; m_flag = nflag; m_pend = npend; m_from_branch = nfb;
        end
    endtask

    // Advance one cycle; inputs are changed only around the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        reset = 0; StallF = 0; StallD = 0; FlushD = 0;
        branch_D = 0; jump_D = 0; target_D = 32'h0;
        branch_E = 0; condition_met_E = 0;
    endtask

    task automatic test_reset();
        logic [31:0] e_pc, e_ins;
        drive_idle();
        reset = 1;
        tick(); tick();
        n_checks++; if (PC_F !== 32'h0) $display("FAIL rst_pc: got %h exp %h", PC_F, 32'h0); else n_pass++;
        n_checks++; if (instr_D !== NOP_V) $display("FAIL rst_instr_d: got %h exp %h", instr_D, NOP_V); else n_pass++;
        n_checks++; if (PC_D !== 32'h0) $display("FAIL rst_pc_d: got %h exp %h", PC_D, 32'h0); else n_pass++;
        n_checks++; if (PCPlus4_D !== 32'h4) $display("FAIL rst_pc4_d: got %h exp %h", PCPlus4_D, 32'h4); else n_pass++;
        n_checks++; if (branched_flag_F !== 1'b0) $display("FAIL rst_flag: got %b exp 0", branched_flag_F); else n_pass++;
        n_checks++; if (dbg_recover_pc !== 32'h0) $display("FAIL rst_recover: got %h exp %h", dbg_recover_pc, 32'h0); else n_pass++;
        n_checks++; if (dbg_state !== ST_SEQ) $display("FAIL rst_state: got %0d exp %0d", dbg_state, ST_SEQ); else n_pass++;
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            e_pc  = 32'(i * 4);
            e_ins = (i == 0) ? NOP_V : mem_word(32'((i - 1) * 4));
            n_checks++; if (PC_F !== e_pc) $display("FAIL seq_pc%0d: got %h exp %h", i, PC_F, e_pc); else n_pass++;
            n_checks++; if (instr_D !== e_ins) $display("FAIL seq_instr_d%0d: got %h exp %h", i, instr_D, e_ins); else n_pass++;
            tick();
        end
    endtask

    task automatic test_branch_mispredict();
        drive_idle();
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (PC_D !== 32'h10) $display("FAIL br_setup_pc_d: got %h exp %h", PC_D, 32'h10); else n_pass++;
        branch_D = 1; target_D = 32'h40; StallD = 1;
        tick();
        n_checks++; if (PC_F !== 32'h40) $display("FAIL br_pc: got %h exp %h", PC_F, 32'h40); else n_pass++;
        n_checks++; if (branched_flag_F !== 1'b1) $display("FAIL br_flag: got %b exp 1", branched_flag_F); else n_pass++;
        n_checks++; if (dbg_recover_pc !== 32'h14) $display("FAIL br_recover: got %h exp %h", dbg_recover_pc, 32'h14); else n_pass++;
        n_checks++; if (PC_D !== 32'h10) $display("FAIL br_pc_d_held: got %h exp %h", PC_D, 32'h10); else n_pass++;
        StallD = 0;  // branch still visible in D, must not redirect twice
        tick();
        n_checks++; if (branched_flag_F !== 1'b0) $display("FAIL br_flag_drop: got %b exp 0", branched_flag_F); else n_pass++;
        n_checks++; if (PC_F !== 32'h44) $display("FAIL br_pc_next: got %h exp %h", PC_F, 32'h44); else n_pass++;
        n_checks++; if (dbg_state !== ST_PEND) $display("FAIL br_state_pend: got %0d exp %0d", dbg_state, ST_PEND); else n_pass++;
        n_checks++; if (instr_D !== mem_word(32'h40)) $display("FAIL br_instr_d: got %h exp %h", instr_D, mem_word(32'h40)); else n_pass++;
        branch_D = 0; branch_E = 1; condition_met_E = 0; StallF = 1; FlushD = 1;
        #1;
        n_checks++; if (mispredict_F !== 1'b1) $display("FAIL mp_comb: got %b exp 1", mispredict_F); else n_pass++;
        tick();
        n_checks++; if (PC_F !== 32'h14) $display("FAIL mp_pc: got %h exp %h", PC_F, 32'h14); else n_pass++;
        n_checks++; if (instr_D !== NOP_V) $display("FAIL mp_instr_d: got %h exp %h", instr_D, NOP_V); else n_pass++;
        n_checks++; if (dbg_state !== ST_SEQ) $display("FAIL mp_state: got %0d exp %0d", dbg_state, ST_SEQ); else n_pass++;
        drive_idle();
    endtask

    task automatic test_jump_stall();
        drive_idle();
        jump_D = 1; target_D = 32'h80; StallF = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (PC_F !== 32'h14) $display("FAIL jmp_hold%0d: got %h exp %h", i, PC_F, 32'h14); else n_pass++;
            n_checks++; if (branched_flag_F !== 1'b0) $display("FAIL jmp_noflag%0d: got %b exp 0", i, branched_flag_F); else n_pass++;
        end
        StallF = 0;
        tick();
        n_checks++; if (PC_F !== 32'h80) $display("FAIL jmp_pc: got %h exp %h", PC_F, 32'h80); else n_pass++;
        n_checks++; if (branched_flag_F !== 1'b1) $display("FAIL jmp_flag: got %b exp 1", branched_flag_F); else n_pass++;
        n_checks++; if (dbg_recover_pc !== 32'h14) $display("FAIL jmp_recover: got %h exp %h", dbg_recover_pc, 32'h14); else n_pass++;
        jump_D = 0;
        tick();
        n_checks++; if (dbg_state !== ST_SEQ) $display("FAIL jmp_state_seq: got %0d exp %0d", dbg_state, ST_SEQ); else n_pass++;
        n_checks++; if (PC_F !== 32'h84) $display("FAIL jmp_pc_next: got %h exp %h", PC_F, 32'h84); else n_pass++;
    endtask

    task automatic test_wrap();
        drive_idle();
        jump_D = 1; target_D = 32'hFFFF_FFFC;
        tick();
        n_checks++; if (PC_F !== 32'hFFFF_FFFC) $display("FAIL wrap_setup: got %h exp %h", PC_F, 32'hFFFF_FFFC); else n_pass++;
        jump_D = 0;
        tick();
        n_checks++; if (PC_F !== 32'h0) $display("FAIL wrap_pc: got %h exp %h", PC_F, 32'h0); else n_pass++;
        n_checks++; if (PC_D !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_d: got %h exp %h", PC_D, 32'hFFFF_FFFC); else n_pass++;
        n_checks++; if (PCPlus4_D !== 32'h0) $display("FAIL wrap_pc4_d: got %h exp %h", PCPlus4_D, 32'h0); else n_pass++;
    endtask

    task automatic test_mispredict_wins();
        drive_idle();
        tick(); tick();
        branch_D = 1; target_D = 32'h100;
        tick();
        n_checks++; if (dbg_recover_pc !== 32'h8) $display("FAIL mw_setup_recover: got %h exp %h", dbg_recover_pc, 32'h8); else n_pass++;
        branch_D = 0;
        tick();
        branch_D = 1; target_D = 32'h200; branch_E = 1; condition_met_E = 0;
        tick();
        n_checks++; if (PC_F !== 32'h8) $display("FAIL mw_pc: got %h exp %h", PC_F, 32'h8); else n_pass++;
        n_checks++; if (branched_flag_F !== 1'b0) $display("FAIL mw_flag: got %b exp 0", branched_flag_F); else n_pass++;
        n_checks++; if (dbg_recover_pc !== 32'h8) $display("FAIL mw_recover: got %h exp %h", dbg_recover_pc, 32'h8); else n_pass++;
        condition_met_E = 1;  // correctly predicted branch: no recovery
        #1;
        n_checks++; if (mispredict_F !== 1'b0) $display("FAIL mw_no_mp: got %b exp 0", mispredict_F); else n_pass++;
        tick();
        n_checks++; if (PC_F !== 32'h200) $display("FAIL mw_redirect_pc: got %h exp %h", PC_F, 32'h200); else n_pass++;
        n_checks++; if (dbg_recover_pc !== 32'h108) $display("FAIL mw_redirect_recover: got %h exp %h", dbg_recover_pc, 32'h108); else n_pass++;
        drive_idle();
    endtask

    task automatic test_flush_stall();
        drive_idle();
        tick(); tick();
        FlushD = 1; StallD = 1;
        tick();
        n_checks++; if (instr_D !== NOP_V) $display("FAIL fs_instr_d: got %h exp %h", instr_D, NOP_V); else n_pass++;
        n_checks++; if (PC_D !== 32'h0) $display("FAIL fs_pc_d: got %h exp %h", PC_D, 32'h0); else n_pass++;
        n_checks++; if (PCPlus4_D !== 32'h4) $display("FAIL fs_pc4_d: got %h exp %h", PCPlus4_D, 32'h4); else n_pass++;
        FlushD = 0;
        tick();
        n_checks++; if (PC_D !== 32'h0) $display("FAIL fs_stall_hold: got %h exp %h", PC_D, 32'h0); else n_pass++;
        drive_idle();
    endtask

    task automatic test_reset_mid_redirect();
        drive_idle();
        tick(); tick();
        branch_D = 1; target_D = 32'h300;
        tick();
        n_checks++; if (branched_flag_F !== 1'b1) $display("FAIL rmr_flag: got %b exp 1", branched_flag_F); else n_pass++;
        branch_D = 0; reset = 1;
        tick();
        n_checks++; if (PC_F !== RST_PC_V) $display("FAIL rmr_pc: got %h exp %h", PC_F, RST_PC_V); else n_pass++;
        n_checks++; if (dbg_recover_pc !== 32'h0) $display("FAIL rmr_recover: got %h exp %h", dbg_recover_pc, 32'h0); else n_pass++;
        n_checks++; if (branched_flag_F !== 1'b0) $display("FAIL rmr_flag_clr: got %b exp 0", branched_flag_F); else n_pass++;
        reset = 0;
        tick();
        n_checks++; if (PC_F !== 32'h4) $display("FAIL rmr_first_fetch: got %h exp %h", PC_F, 32'h4); else n_pass++;
    endtask

    task automatic test_random();
        fetch_state_e exp_st;
        logic [31:0]  t;
        drive_idle();
        reset = 1; tick(); reset = 0;
        for (int c = 0; c < 600; c++) begin
            reset           = ($urandom_range(0, 63) == 0);
            StallF          = ($urandom_range(0, 3) == 0);
            StallD          = ($urandom_range(0, 3) == 0);
            FlushD          = ($urandom_range(0, 7) == 0);
            branch_D        = ($urandom_range(0, 4) == 0);
            jump_D          = ($urandom_range(0, 7) == 0);
            t               = $urandom;
            t[1:0]          = 2'b00;
            target_D        = t;
            branch_E        = ($urandom_range(0, 5) == 0);
            condition_met_E = $urandom_range(0, 1) == 1;
            #1;
            n_checks++; if (mispredict_F !== (branch_E && !condition_met_E)) $display("FAIL rnd_mp c%0d: got %b exp %b", c, mispredict_F, branch_E && !condition_met_E); else n_pass++;
            tick();
            exp_st = m_flag ? ST_REDIR : (m_pend ? ST_PEND : ST_SEQ);
            n_checks++; if (PC_F !== m_pc) $display("FAIL rnd_pc c%0d: got %h exp %h", c, PC_F, m_pc); else n_pass++;
            n_checks++; if (instr_D !== m_instr_d) $display("FAIL rnd_instr_d c%0d: got %h exp %h", c, instr_D, m_instr_d); else n_pass++;
            n_checks++; if (PC_D !== m_pc_d) $display("FAIL rnd_pc_d c%0d: got %h exp %h", c, PC_D, m_pc_d); else n_pass++;
            n_checks++; if (PCPlus4_D !== m_pc4_d) $display("FAIL rnd_pc4_d c%0d: got %h exp %h", c, PCPlus4_D, m_pc4_d); else n_pass++;
            n_checks++; if (branched_flag_F !== m_flag) $display("FAIL rnd_flag c%0d: got %b exp %b", c, branched_flag_F, m_flag); else n_pass++;
            n_checks++; if (dbg_recover_pc !== m_recover) $display("FAIL rnd_recover c%0d: got %h exp %h", c, dbg_recover_pc, m_recover); else n_pass++;
            n_checks++; if (dbg_state !== exp_st) $display("FAIL rnd_state c%0d: got %0d exp %0d", c, dbg_state, exp_st); else n_pass++;
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        reset = 1;
        @(negedge clk);
        test_reset();
        test_branch_mispredict();
        test_jump_stall();
        test_wrap();
        test_mispredict_wins();
        test_flush_stall();
        test_reset_mid_redirect();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
